branch_predictor: RTL and testbench

- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- The IF stage looks up the current PC to get a predicted next PC.
- The EX stage feeds back the branch comparator's resolved outcome to train the table and to detect mispredictions.
- On a misprediction, the block produces the redirect PC and flush request used by the PC mux and the IF/ID and ID/EX pipeline registers.

---
 rtl/branch_predictor.sv | 137 +++++++++++++
 tb/tb_branch_predictor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF lookup,
// EX-stage training, misprediction redirect and saturating perf counters.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam int unsigned TAG_LSB = INDEX_BITS + 2;
    localparam logic [1:0]  CTR_WEAK_T   = 2'b10;
    localparam logic [1:0]  CTR_STRONG_T = 2'b11;
    localparam logic [1:0]  CTR_STRONG_N = 2'b00;
    localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          ctr_d    [ENTRIES];
    logic [31:0]         branch_cnt_q, branch_cnt_d;
    logic [31:0]         mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    logic                  if_hit, ex_hit;
    logic                  upd_en;
    logic                  target_wrong;
    logic                  unused_pc_bits;

    assign if_idx = if_pc[TAG_LSB-1:2];
    assign if_tag = if_pc[31:TAG_LSB];
    assign ex_idx = ex_pc[TAG_LSB-1:2];
    assign ex_tag = ex_pc[31:TAG_LSB];

    // Byte-offset bits never address the table.
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // IF lookup reads registered state only, so same-cycle updates are not bypassed.
    always_comb begin
        if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = !rst && if_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
    end

    // Resolution check: wrong direction, or right direction with a stale target.
    always_comb begin
        target_wrong = ex_taken && ex_pred_taken && (ex_pred_target != ex_target);
        mispredict   = !rst && ex_valid && ((ex_taken != ex_pred_taken) || target_wrong);
        redirect_pc  = ex_taken ? ex_target : ex_pc + 32'd4;
    end

    assign upd_en = ex_valid && !rst;
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Table training: copy current state, then modify the one resolved entry.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (upd_en) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    if (ctr_q[ex_idx] != CTR_STRONG_T) begin
                        ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                    end
                    target_d[ex_idx] = ex_target;
                end else if (ctr_q[ex_idx] != CTR_STRONG_N) begin
                    ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
                end
                if (!ex_is_branch) begin
                    ctr_d[ex_idx] = CTR_STRONG_T;
                end
            end else if (ex_taken) begin
                // Allocation silently evicts whatever aliased into this slot.
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_target;
                ctr_d[ex_idx]    = ex_is_branch ? CTR_WEAK_T : CTR_STRONG_T;
            end
        end
    end

    // Saturating performance counters.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_en && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Payload arrays are masked by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        ctr_q    <= ctr_d;
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random traffic
// checked against an entry-level behavioural model of the BTB.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    typedef struct {
        logic        p_taken;
        logic [31:0] p_target;
        logic        mis;
        logic [31:0] redir;
        logic        chk_cnt;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: each slot remembers which line owns it, where it goes,
    // and a confidence level 0..3 where 2 and above means "taken".
    bit          m_valid [64];
    logic [31:0] m_owner [64];
    logic [31:0] m_dest  [64];
    int          m_conf  [64];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic logic [31:0] owner_of(input logic [31:0] pc);
        return pc / 256;
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_owner[slot_of(pc)] == owner_of(pc));
    endfunction

    task automatic model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
        t   = model_hit(pc) && (m_conf[slot_of(pc)] >= 2);
        tgt = t ? m_dest[slot_of(pc)] : pc + 32'd4;
    endtask

    task automatic model_update(input logic r, input logic ev, input logic eb,
                                input logic [31:0] epc, input logic et,
                                input logic [31:0] etg, input logic mis);
        int s;
        if (r) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 0;
            m_bcnt = 0;
            m_mcnt = 0;
            return;
        end
        if (!ev) return;
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
        if (mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
        s = slot_of(epc);
        if (model_hit(epc)) begin
            if (et) begin
                m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
                m_dest[s] = etg;
            end else begin
                m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
            end
            if (!eb) m_conf[s] = 3;
        end else if (et) begin
            m_valid[s] = 1;
            m_owner[s] = owner_of(epc);
            m_dest[s]  = etg;
            m_conf[s]  = eb ? 2 : 3;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive, enqueue the model's expectation, then train the model.
    task automatic step(input logic r, input logic [31:0] ipc, input logic ev, input logic eb,
                        input logic [31:0] epc, input logic et, input logic [31:0] etg,
                        input logic ept, input logic [31:0] eptg);
        exp_t        e;
        logic        pt;
        logic [31:0] ptg;
        @(posedge clk);
        #1;
        rst = r; if_pc = ipc; ex_valid = ev; ex_is_branch = eb; ex_pc = epc;
        ex_taken = et; ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
        model_predict(ipc, pt, ptg);
        e.p_taken  = r ? 1'b0 : pt;
        e.p_target = r ? ipc + 32'd4 : ptg;
        e.mis      = !r && ev && ((et != ept) || (et && ept && (eptg != etg)));
        e.redir    = et ? etg : epc + 32'd4;
        e.chk_cnt  = !r;
        e.bcnt     = m_bcnt;
        e.mcnt     = m_mcnt;
        exp_q.push_back(e);
        model_update(r, ev, eb, epc, et, etg, e.mis);
    endtask

    task automatic lookup(input logic [31:0] ipc);
        step(1'b0, ipc, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle, so compare at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_pred_taken", 32'(pred_taken), 32'(e.p_taken));
                check("sb_pred_target", pred_target, e.p_target);
                check("sb_mispredict", 32'(mispredict), 32'(e.mis));
                if (e.mis) check("sb_redirect_pc", redirect_pc, e.redir);
                if (e.chk_cnt) begin
                    check("sb_branch_cnt", branch_cnt, e.bcnt);
                    check("sb_mispred_cnt", mispred_cnt, e.mcnt);
                end
            end
        end
    end

    initial begin
        logic        r, ev, eb, et, ept;
        logic [31:0] ipc, epc, etg, eptg;

        rst = 1'b1; if_pc = 32'h0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pc = 32'h0;
        ex_taken = 1'b0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;
        m_bcnt = 0;
        m_mcnt = 0;
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0; m_owner[i] = 0; m_dest[i] = 0; m_conf[i] = 0;
        end

        // Reset state
        step(1'b1, 32'h100, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        lookup(32'h100);
        settle();
        check("rst_pred_taken", 32'(pred_taken), 32'h0);
        check("rst_pred_target", pred_target, 32'h104);
        check("rst_branch_cnt", branch_cnt, 32'h0);
        check("rst_mispred_cnt", mispred_cnt, 32'h0);

        // Cold-miss allocation
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        settle();
        check("alloc_mispredict", 32'(mispredict), 32'h1);
        check("alloc_redirect", redirect_pc, 32'h80);
        lookup(32'h100);
        settle();
        check("alloc_pred_taken", 32'(pred_taken), 32'h1);
        check("alloc_pred_target", pred_target, 32'h80);
        check("alloc_branch_cnt", branch_cnt, 32'h1);
        check("alloc_mispred_cnt", mispred_cnt, 32'h1);

        // Counter walk down to strong not-taken and back up one step
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        settle();
        check("walk1_mispredict", 32'(mispredict), 32'h1);
        check("walk1_redirect", redirect_pc, 32'h104);
        step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
        settle();
        check("walk2_pred_taken", 32'(pred_taken), 32'h0);
        check("walk2_mispredict", 32'(mispredict), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        lookup(32'h100);
        settle();
        check("walk_up_pred_taken", 32'(pred_taken), 32'h0);

        // Alias eviction
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        lookup(32'h100);
        settle();
        check("alias_old_taken", 32'(pred_taken), 32'h0);
        check("alias_old_target", pred_target, 32'h104);
        lookup(32'h200);
        settle();
        check("alias_new_target", pred_target, 32'h300);

        // Wrong target on a strongly-taken entry
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h90, 1'b1, 32'h80);
        settle();
        check("wrongtgt_mispredict", 32'(mispredict), 32'h1);
        check("wrongtgt_redirect", redirect_pc, 32'h90);
        lookup(32'h100);
        settle();
        check("wrongtgt_new_target", pred_target, 32'h90);

        // Same-cycle lookup and update of one index
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
        step(1'b0, 32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
        settle();
        check("hazard_same_cycle", 32'(pred_taken), 32'h1);
        lookup(32'h100);
        settle();
        check("hazard_next_cycle", 32'(pred_taken), 32'h0);

        // Reset with an update in flight
        step(1'b1, 32'h140, 1'b1, 1'b1, 32'h140, 1'b1, 32'h500, 1'b0, 32'h144);
        settle();
        check("rst_mid_mispredict", 32'(mispredict), 32'h0);
        lookup(32'h140);
        settle();
        check("rst_mid_no_alloc", 32'(pred_taken), 32'h0);
        check("rst_mid_target", pred_target, 32'h144);
        check("rst_mid_branch_cnt", branch_cnt, 32'h0);
        check("rst_mid_mispred_cnt", mispred_cnt, 32'h0);

        // PC+4 wrap at the top of the address space
        step(1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h40);
        settle();
        check("wrap_pred_target", pred_target, 32'h0);
        check("wrap_redirect", redirect_pc, 32'h0);

        // Randomized traffic over a small PC pool so entries hit, alias and evict
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            ipc = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC
                : ((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2));
            epc = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFC
                : ((32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2));
            ev  = ($urandom_range(0, 9) < 7);
            eb  = ($urandom_range(0, 3) != 0);
            et  = eb ? 1'($urandom_range(0, 1)) : 1'b1;
            etg = 32'($urandom_range(0, 15)) << 4;
            if ($urandom_range(0, 9) < 7) begin
                model_predict(epc, ept, eptg);
            end else begin
                ept  = 1'($urandom_range(0, 1));
                eptg = 32'($urandom_range(0, 15)) << 4;
            end
            step(r, ipc, ev, eb, epc, et, etg, ept, eptg);
        end

        @(posedge clk);
        settle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
